// File: rtl/apb_pkg.sv
// Shared APB completer definitions: FSM state encoding, response codes and
// the byte-strobe merge used on register writes.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    localparam logic APB_OKAY   = 1'b0;
    localparam logic APB_SLVERR = 1'b1;

    localparam int CNT_W = 4;

    function automatic logic [31:0] apb_strb_merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old;
        for (int n = 0; n < 4; n++) begin
            if (strb[n]) res[8*n +: 8] = wdata[8*n +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB address decoder: byte address to word index plus error
// flag (below base, past last register, unaligned, write to read-only reg 0).
module apb_addr_decode #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_REGS  = 16,
    parameter int          IDX_W     = $clog2(NUM_REGS)
) (
    input  logic [31:0]      paddr,
    input  logic             pwrite,
    output logic [IDX_W-1:0] index,
    output logic             err
);

    logic [31:0] offset;
    logic [29:0] word;

    assign offset = paddr - BASE_ADDR;
    assign word   = offset[31:2];
    assign index  = word[IDX_W-1:0];

    // BASE_ADDR is word aligned, so offset[1:0] equals paddr[1:0]; the full
    // 30-bit word compare keeps high offsets from aliasing onto low registers.
    always_comb begin
        err = (paddr < BASE_ADDR)
           || (word >= 30'(NUM_REGS))
           || (offset[1:0] != 2'b00)
           || (pwrite && (word == 30'd0));
    end

endmodule

// File: rtl/apb_slave_regs.sv
// APB3/APB4 completer register bank with programmable wait states, byte
// strobes, read-only ID register and per-register write pulses.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | no transfer; a SETUP (psel & !penable) captures the request
//  ACCESS | waiting on counter; pready when it reaches zero, abort on
//         | psel/penable dropping
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                     s_apb_pclk,
    input  logic                     s_apb_preset,
    input  logic [31:0]              s_apb_paddr,
    input  logic                     s_apb_psel,
    input  logic                     s_apb_penable,
    input  logic                     s_apb_pwrite,
    input  logic [31:0]              s_apb_pwdata,
    input  logic [3:0]               s_apb_pstrb,
    input  logic [2:0]               s_apb_pprot,
    output logic                     s_apb_pready,
    output logic [31:0]              s_apb_prdata,
    output logic                     s_apb_pslverr,
    output logic [32*NUM_REGS-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    localparam int IDX_W = $clog2(NUM_REGS);

    apb_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic               wr;
    logic [31:0]        wdata;
    logic [3:0]         strb;
    logic               err;
    logic [31:0]        rdata;
    logic [31:0]        regs_q [1:NUM_REGS-1];
    logic [31:0]        view   [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q;

    logic [IDX_W-1:0]   dec_index;
    logic               dec_err;
    logic               unused_pprot;

    assign unused_pprot = ^s_apb_pprot;

    apb_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W)
    ) u_decode (
        .paddr  (s_apb_paddr),
        .pwrite (s_apb_pwrite),
        .index  (dec_index),
        .err    (dec_err)
    );

    always_comb begin
        view[0] = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            view[i] = regs_q[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[32*g +: 32] = view[g];
    end

    assign s_apb_pready  = (state == ACCESS) && s_apb_psel && s_apb_penable && (cnt == '0);
    assign s_apb_pslverr = (s_apb_pready && err) ? APB_SLVERR : APB_OKAY;
    assign s_apb_prdata  = (s_apb_pready && !wr) ? rdata : 32'h0;
    assign wr_pulse_o    = wr_pulse_q;

    always_ff @(posedge s_apb_pclk or posedge s_apb_preset) begin
        if (s_apb_preset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            wr         <= 1'b0;
            wdata      <= '0;
            strb       <= '0;
            err        <= 1'b0;
            rdata      <= '0;
            wr_pulse_q <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            wr_pulse_q <= '0;
            case (state)
                IDLE: begin
                    if (s_apb_psel && !s_apb_penable) begin
                        state <= ACCESS;
                        idx   <= dec_index;
                        wr    <= s_apb_pwrite;
                        wdata <= s_apb_pwdata;
                        strb  <= s_apb_pstrb;
                        err   <= dec_err;
                        // Read data is frozen at SETUP so a concurrent write can't tear it.
                        rdata <= dec_err ? 32'h0 : view[dec_index];
                        cnt   <= CNT_W'(WAIT_STATES);
                    end
                end
                ACCESS: begin
                    if (!s_apb_psel || !s_apb_penable) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                        if (wr && !err) begin
                            for (int i = 1; i < NUM_REGS; i++) begin
                                if (idx == IDX_W'(i)) begin
                                    regs_q[i] <= apb_strb_merge(regs_q[i], wdata, strb);
                                end
                            end
                            wr_pulse_q[idx] <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Scoreboard bench for apb_slave_regs: three instances with 0, 3 and 2 wait
// states share one APB bus, each selected by its own psel bit.
module tb_apb_slave_regs;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    logic        clk;
    logic        rst;
    logic [31:0] paddr;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    logic        pready0, pready1, pready2;
    logic [31:0] prdata0, prdata1, prdata2;
    logic        pslverr0, pslverr1, pslverr2;
    logic [511:0] regs0, regs1, regs2;
    logic [15:0] wrp0, wrp1, wrp2;

    int          cur;
    logic        c_pready;
    logic [31:0] c_prdata;
    logic        c_pslverr;
    logic [511:0] c_regs;
    logic [15:0] c_wrp;

    logic [31:0] model [3][16];

    int n_checks;
    int n_errors;

    apb_slave_regs #(.WAIT_STATES(0)) dut0 (
        .s_apb_pclk(clk), .s_apb_preset(rst), .s_apb_paddr(paddr), .s_apb_psel(psel[0]),
        .s_apb_penable(penable), .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata),
        .s_apb_pstrb(pstrb), .s_apb_pprot(pprot), .s_apb_pready(pready0),
        .s_apb_prdata(prdata0), .s_apb_pslverr(pslverr0), .regs_o(regs0), .wr_pulse_o(wrp0)
    );

    apb_slave_regs #(.WAIT_STATES(3)) dut1 (
        .s_apb_pclk(clk), .s_apb_preset(rst), .s_apb_paddr(paddr), .s_apb_psel(psel[1]),
        .s_apb_penable(penable), .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata),
        .s_apb_pstrb(pstrb), .s_apb_pprot(pprot), .s_apb_pready(pready1),
        .s_apb_prdata(prdata1), .s_apb_pslverr(pslverr1), .regs_o(regs1), .wr_pulse_o(wrp1)
    );

    apb_slave_regs #(.WAIT_STATES(2)) dut2 (
        .s_apb_pclk(clk), .s_apb_preset(rst), .s_apb_paddr(paddr), .s_apb_psel(psel[2]),
        .s_apb_penable(penable), .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata),
        .s_apb_pstrb(pstrb), .s_apb_pprot(pprot), .s_apb_pready(pready2),
        .s_apb_prdata(prdata2), .s_apb_pslverr(pslverr2), .regs_o(regs2), .wr_pulse_o(wrp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (cur)
            0: begin
                c_pready = pready0; c_prdata = prdata0; c_pslverr = pslverr0;
                c_regs = regs0; c_wrp = wrp0;
            end
            1: begin
                c_pready = pready1; c_prdata = prdata1; c_pslverr = pslverr1;
                c_regs = regs1; c_wrp = wrp1;
            end
            default: begin
                c_pready = pready2; c_prdata = prdata2; c_pslverr = pslverr2;
                c_regs = regs2; c_wrp = wrp2;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 2;
    endfunction

    function automatic logic [31:0] byte_write(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] st);
        logic [31:0] mask;
        mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
        return (old & ~mask) | (wd & mask);
    endfunction

    // Issues one transfer on instance d; returns 1 ns after the edge that
    // closes it, with psel/penable still high so a new SETUP can follow at once.
    task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st, input logic exp_err);
        exp_t e;
        int   n;
        int   slot;
        logic seen;
        logic commit;
        slot   = int'(addr[5:2]);
        commit = wr && !exp_err;
        e.rdata = (wr || exp_err) ? 32'h0 : ((slot == 0) ? ID : model[d][slot]);
        e.err   = exp_err;
        e.lat   = 2 + ws_of(d);
        sb.push_back(e);

        cur     = d;
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wd;
        pstrb   = st;
        @(posedge clk);
        #1 penable = 1'b1;
        #1;
        n    = 2;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (c_pready) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk("prdata",  c_prdata,  e.rdata);
                chk("pslverr", 32'(c_pslverr), 32'(e.err));
                chk("latency", n, e.lat);
                chk("slot_before", c_regs[32*slot +: 32], (slot == 0) ? ID : model[d][slot]);
            end else begin
                @(posedge clk);
                #2;
                n++;
            end
        end
        if (!seen) begin
            chk("pready_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        if (commit) model[d][slot] = byte_write(model[d][slot], wd, st);
        @(posedge clk);
        #1;
        chk("wr_pulse", 32'(c_wrp), commit ? (32'd1 << slot) : 32'd0);
        chk("slot_after", c_regs[32*slot +: 32], (slot == 0) ? ID : model[d][slot]);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cur      = 0;
        rst      = 1'b1;
        paddr    = '0;
        psel     = '0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        pwdata   = '0;
        pstrb    = '0;
        pprot    = '0;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++) model[d][i] = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready",  32'(c_pready), 32'd0);
        chk("rst_prdata",  c_prdata, 32'd0);
        chk("rst_pslverr", 32'(c_pslverr), 32'd0);
        chk("rst_wrp",     32'(c_wrp), 32'd0);
        chk("rst_slot0",   c_regs[31:0], ID);
        chk("rst_slot1",   c_regs[63:32], 32'd0);
        rst = 1'b0;

        xfer(0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);

        xfer(0, 32'h4, 1'b1, 32'hDEAD_BEEF, 4'b0101, 1'b0);
        psel = '0;
        @(posedge clk);
        #1;
        chk("pulse_one_cycle", 32'(c_wrp), 32'd0);
        xfer(0, 32'h4, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("model_0x4", model[0][1], 32'h00AD_00EF);

        xfer(1, 32'h8, 1'b0, 32'h0, 4'h0, 1'b0);

        xfer(0, 32'h40, 1'b0, 32'h0, 4'h0, 1'b1);
        xfer(0, 32'h6,  1'b0, 32'h0, 4'h0, 1'b1);
        xfer(0, 32'h0,  1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1);
        xfer(0, 32'h3C, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0);
        xfer(0, 32'h3C, 1'b0, 32'h0, 4'h0, 1'b0);
        xfer(0, 32'h4,  1'b1, 32'h1111_1111, 4'h0, 1'b0);
        xfer(0, 32'h4,  1'b0, 32'h0, 4'h0, 1'b0);

        xfer(0, 32'hC, 1'b1, 32'h1234_5678, 4'hF, 1'b0);
        xfer(0, 32'hC, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("model_0xc", model[0][3], 32'h1234_5678);

        cur     = 2;
        psel    = 3'b100;
        penable = 1'b0;
        paddr   = 32'h4;
        pwrite  = 1'b1;
        pwdata  = 32'hFFFF_FFFF;
        pstrb   = 4'hF;
        @(posedge clk);
        #1 penable = 1'b1;
        @(posedge clk);
        #1 penable = 1'b0;
        #1 chk("abort_pready", 32'(c_pready), 32'd0);
        @(posedge clk);
        #1 psel = '0;
        chk("abort_wrp0", 32'(c_wrp), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_wrp1", 32'(c_wrp), 32'd0);
        chk("abort_slot1", c_regs[63:32], 32'd0);
        xfer(2, 32'h4, 1'b0, 32'h0, 4'h0, 1'b0);

        cur     = 0;
        psel    = 3'b001;
        penable = 1'b0;
        paddr   = 32'h10;
        pwrite  = 1'b1;
        pwdata  = 32'hA5A5_A5A5;
        pstrb   = 4'hF;
        @(posedge clk);
        #1 penable = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_pready",  32'(c_pready), 32'd0);
        chk("mid_rst_prdata",  c_prdata, 32'd0);
        chk("mid_rst_pslverr", 32'(c_pslverr), 32'd0);
        chk("mid_rst_wrp",     32'(c_wrp), 32'd0);
        chk("mid_rst_slot0",   c_regs[31:0], ID);
        chk("mid_rst_slot4",   c_regs[159:128], 32'd0);
        chk("mid_rst_slot3",   c_regs[127:96], 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        psel    = '0;
        penable = 1'b0;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
        @(posedge clk);
        #1;
        chk("post_rst_wrp", 32'(c_wrp), 32'd0);
        xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, 1'b0);
        xfer(0, 32'h4,  1'b0, 32'h0, 4'h0, 1'b0);
        psel = '0;
        penable = 1'b0;
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
